// File: rtl/im_loader.sv
// Boot-time instruction memory loader: byte stream in, little-endian 32-bit IM writes out.
// Optional trailing XOR checksum byte when IM_LOADER_CHECKSUM_EN is defined.
module im_loader #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_WORD  = 3'd3,
    S_FLUSH = 3'd4,
`ifdef IM_LOADER_CHECKSUM_EN
    S_CHK   = 3'd5,
`endif
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [15:0] LEN_MAX = 16'(DEPTH_WORDS);

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CHK;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t              r_state;
  state_t              w_next;
  logic                w_acc;
  logic [15:0]         w_len;
  logic                w_last_word;

  logic [7:0]          r_len_lo;
  logic [15:0]         r_n;
  logic [15:0]         r_k;
  logic [1:0]          r_bidx;
  logic [23:0]         r_asm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
`endif

  assign w_acc       = rx_valid && rx_ready;
  assign w_len       = {rx_data, r_len_lo};
  assign w_last_word = (r_k == (r_n - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The last word gets one extra FLUSH cycle so done rises only after its write pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN0;
      end
      S_LEN0: begin
        if (w_acc) w_next = S_LEN1;
      end
      S_LEN1: begin
        if (w_acc) begin
          if (w_len == 16'd0)       w_next = S_AFTER;
          else if (w_len > LEN_MAX) w_next = S_ERR;
          else                      w_next = S_WORD;
        end
      end
      S_WORD: begin
        if (w_acc && (r_bidx == 2'd3) && w_last_word) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_next = S_AFTER;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_acc) w_next = (rx_data == r_xor) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) w_next = S_LEN0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      S_IDLE:                 cpu_hold = 1'b0;
      S_LEN0, S_LEN1, S_WORD: rx_ready = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK:                  rx_ready = 1'b1;
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:                  err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_lo <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_bidx   <= '0;
      r_asm    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_xor    <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_LEN0: r_len_lo <= rx_data;
          S_LEN1: begin
            r_n    <= w_len;
            r_k    <= '0;
            r_bidx <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_xor  <= '0;
`endif
          end
          S_WORD: begin
            r_bidx <= r_bidx + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            r_xor  <= r_xor ^ rx_data;
`endif
            // Bytes enter at the top so b0 ends up in the low lane.
            if (r_bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {rx_data, r_asm};
              r_waddr <= ADDR_W'({r_k, 2'b00});
              r_k     <= r_k + 16'd1;
            end else begin
              r_asm   <= {rx_data, r_asm[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader against a queue-based image model.
module tb_im_loader;
  localparam int DEPTH_WORDS = 128;
  localparam int ADDR_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  stim[$];
  logic [47:0] exp_w[$];
  logic [47:0] got_w[$];
  logic        exp_done;
  logic        exp_err;
  int          n_send;
  int          n_pay;

  im_loader #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && we) got_w.push_back({waddr, wdata});
  end

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: derive writes and final status straight from the byte image.
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    x = 8'h00;
    n = int'({stim[1], stim[0]});
    if (n > DEPTH_WORDS) begin
      exp_err = 1'b1;
      n_send  = 2;
      n_pay   = 0;
    end else begin
      for (int k = 0; k < n; k++) begin
        w = {stim[5+4*k], stim[4+4*k], stim[3+4*k], stim[2+4*k]};
        x ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        exp_w.push_back({16'(4*k), w});
      end
      n_pay  = n;
      n_send = 2 + 4*n;
`ifdef IM_LOADER_CHECKSUM_EN
      n_send++;
      exp_err  = (stim[2+4*n] != x);
      exp_done = !exp_err;
`else
      exp_done = (x == x);
`endif
    end
  endtask

  task automatic add_chk(input bit bad);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    if (bad) x ^= 8'h01;
`ifdef IM_LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
  endtask

  task automatic make_image(input int n, input bit bad);
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    if (n <= DEPTH_WORDS) begin
      for (int i = 0; i < 4*n; i++) stim.push_back(8'($urandom));
      add_chk(bad);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input bit with_start);
    int g;
    g = int'($urandom_range(gmax, gmin));
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    g = 0;
    while (!rx_ready && g < 64) begin
      @(negedge clk);
      start = 1'b0;
      g++;
    end
    if (g >= 64) check_eq("rdy_wait", 48'(rx_ready), 48'(1));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_session(input int gmin, input int gmax, input int start_at, input string tag);
    int g;
    model();
    got_w.delete();
    pulse_start();
    check_eq({tag, "_ld_rdy"}, 48'(rx_ready), 48'(1));
    check_eq({tag, "_ld_hold"}, 48'(cpu_hold), 48'(1));
    check_eq({tag, "_ld_flags"}, 48'({done, err}), 48'(0));
    for (int i = 0; i < n_send; i++) begin
      send_byte(stim[i], gmin, gmax, i == start_at);
      if (n_pay > 0 && i == 1 + 4*n_pay) begin
        check_eq({tag, "_we_lat"}, 48'(we), 48'(1));
        check_eq({tag, "_done_early"}, 48'(done), 48'(0));
`ifndef IM_LOADER_CHECKSUM_EN
        @(posedge clk);
        #1;
        check_eq({tag, "_done_lat"}, 48'(done), 48'(1));
`endif
      end
    end
    g = 0;
    while (!(done || err) && g < 32) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq({tag, "_done"}, 48'(done), 48'(exp_done));
    check_eq({tag, "_err"}, 48'(err), 48'(exp_err));
    check_eq({tag, "_hold"}, 48'(cpu_hold), 48'(exp_err));
    check_eq({tag, "_rdy_end"}, 48'(rx_ready), 48'(0));
    check_eq({tag, "_nwr"}, 48'(got_w.size()), 48'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check_eq({tag, "_wr"}, got_w[i], exp_w[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ctl"}, 48'({we, done, err, cpu_hold, rx_ready}), 48'(0));
    check_eq({tag, "_waddr"}, 48'(waddr), 48'(0));
    check_eq({tag, "_wdata"}, 48'(wdata), 48'(0));
  endtask

  initial begin
    int n;
    int sa;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Two-word program from the boot example.
    stim = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h00, 8'h10, 8'h73, 8'h90, 8'h52, 8'h00};
    add_chk(1'b0);
    run_session(0, 0, -1, "t1");
    if (got_w.size() == 2) begin
      check_eq("t1_w0", got_w[0], {16'h0000, 32'h10000293});
      check_eq("t1_w1", got_w[1], {16'h0004, 32'h00529073});
    end

    // Over-capacity length is rejected before any write.
    stim = '{8'h81, 8'h00};
    run_session(0, 0, -1, "t2");

    // Gapped single word, then a byte held while the loader is not ready.
    stim = '{8'h01, 8'h00, 8'h93, 8'h08, 8'ha0, 8'h00};
    add_chk(1'b0);
    run_session(1, 3, -1, "t3");
    if (got_w.size() == 1) check_eq("t3_w0", got_w[0], {16'h0000, 32'h00a00893});
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_eq("t3_idle_rdy", 48'(rx_ready), 48'(0));
    end
    check_eq("t3_idle_done", 48'(done), 48'(1));
    check_eq("t3_idle_nwr", 48'(got_w.size()), 48'(1));
    @(negedge clk);
    rx_valid = 1'b0;

    // Reset in the middle of word 0, then a fresh image.
    pulse_start();
    send_byte(8'h01, 0, 0, 1'b0);
    send_byte(8'h00, 0, 0, 1'b0);
    send_byte(8'h11, 0, 0, 1'b0);
    send_byte(8'h22, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("t4_rst");
    @(negedge clk);
    rst_n = 1'b1;
    stim = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
    add_chk(1'b0);
    run_session(0, 1, -1, "t4");
    if (got_w.size() == 1) check_eq("t4_w0", got_w[0], {16'h0000, 32'hdeadbeef});

`ifdef IM_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_session(0, 0, -1, "t5_ok");
    check_eq("t5_ok_done", 48'(done), 48'(1));
    stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_session(0, 0, -1, "t5_bad");
    check_eq("t5_bad_err", 48'(err), 48'(1));
    check_eq("t5_bad_nwr", 48'(got_w.size()), 48'(1));
`endif

    // Start during WORD is ignored; the following session reloads from address 0.
    make_image(3, 1'b0);
    run_session(0, 1, 5, "t6_mid");
    make_image(2, 1'b0);
    run_session(0, 0, -1, "t6_reload");

    // Boundaries: empty image and exactly full capacity.
    make_image(0, 1'b0);
    run_session(0, 1, -1, "n0");
    make_image(DEPTH_WORDS, 1'b0);
    run_session(0, 0, -1, "nmax");

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(5, 0))
        0:       n = 0;
        1:       n = DEPTH_WORDS + 1 + int'($urandom_range(400, 0));
        default: n = int'($urandom_range(6, 1));
      endcase
      make_image(n, $urandom_range(3, 0) == 0);
      sa = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8, 2)) : -1;
      run_session(0, 2, sa, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
